// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the TX framer state type.
// Imported by the framer and by the CRC helper.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IPG
    } tx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 step over one byte.
// Shared between the TX framer and the RX checker.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  d,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    always_comb begin
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        crc_next = c;
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, pad, FCS, then IPG.
// One byte per clock; all wire outputs are registered.
module gmii_tx_framer
    import eth_pkg::*;
#(
    parameter int unsigned ipg     = 12,
    parameter int unsigned min_len = 60,
    parameter bit          pad_en  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_ready,
    input  logic [7:0] in_d,
    input  logic       in_last,
    output logic       in_re,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       busy
);

    tx_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] len_q, len_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;

    logic [7:0]  crc_byte;
    logic [31:0] crc_upd;
    logic [10:0] len_inc;
    logic        pad_more;

    assign crc_byte = (state_q == ST_DATA) ? in_d : 8'h00;

    crc32_d8 u_crc (
        .crc      (crc_q),
        .d        (crc_byte),
        .crc_next (crc_upd)
    );

    // Saturation is only reachable well above min_len, so padding stays exact.
    assign len_inc  = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
    assign pad_more = pad_en && (32'(len_inc) < min_len);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        crc_d   = crc_q;
        txd_d   = 8'h00;
        tx_en_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_ready) begin
                    state_d = ST_PRE;
                    cnt_d   = 8'd0;
                end
            end
            ST_PRE: begin
                txd_d   = ETH_PREAMBLE;
                tx_en_d = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                if (cnt_q == 8'd6) state_d = ST_SFD;
            end
            ST_SFD: begin
                txd_d   = ETH_SFD;
                tx_en_d = 1'b1;
                crc_d   = CRC32_INIT;
                len_d   = 11'd0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                txd_d   = in_d;
                tx_en_d = 1'b1;
                crc_d   = crc_upd;
                len_d   = len_inc;
                if (in_last) begin
                    cnt_d   = 8'd0;
                    state_d = pad_more ? ST_PAD : ST_FCS;
                end
            end
            ST_PAD: begin
                tx_en_d = 1'b1;
                crc_d   = crc_upd;
                len_d   = len_inc;
                if (!pad_more) begin
                    cnt_d   = 8'd0;
                    state_d = ST_FCS;
                end
            end
            ST_FCS: begin
                // Shift the register down so the next FCS byte is always [7:0].
                txd_d   = ~crc_q[7:0];
                tx_en_d = 1'b1;
                crc_d   = {8'h00, crc_q[31:8]};
                cnt_d   = cnt_q + 8'd1;
                if (cnt_q == 8'd3) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IPG;
                end
            end
            ST_IPG: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(ipg - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            len_q   <= 11'd0;
            crc_q   <= CRC32_INIT;
            txd_q   <= 8'h00;
            tx_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            crc_q   <= crc_d;
            txd_q   <= txd_d;
            tx_en_q <= tx_en_d;
        end
    end

    assign in_re      = (state_q == ST_DATA);
    assign busy       = (state_q != ST_IDLE);
    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer with a queue-based frame model.
// dut0 runs without padding, dut1 with padding to 60 bytes.
module tb_gmii_tx_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_ready;
    logic        sel;
    logic [7:0]  in_d;
    logic        in_last;
    logic        re0, re1, ten0, ten1, b0, b1;
    logic [7:0]  txd0, txd1;
    logic        in_re_a, tx_en_a, busy_a;
    logic [7:0]  txd_a;

    logic [7:0]  pkt_mem [0:2047];
    int          pkt_len;
    logic [10:0] idx;

    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];

    int checks   = 0;
    int failures = 0;

    assign in_d    = pkt_mem[idx];
    assign in_last = (int'(idx) == pkt_len - 1);
    assign in_re_a = sel ? re1 : re0;
    assign tx_en_a = sel ? ten1 : ten0;
    assign busy_a  = sel ? b1 : b0;
    assign txd_a   = sel ? txd1 : txd0;

    // First-word-fall-through source feeding whichever DUT is selected
    always @(posedge clk) begin
        if (!rst_n) idx <= 11'd0;
        else if (in_re_a) idx <= in_last ? 11'd0 : idx + 11'd1;
    end

    gmii_tx_framer #(.ipg(12), .min_len(60), .pad_en(1'b0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_ready   (in_ready & ~sel),
        .in_d       (in_d),
        .in_last    (in_last),
        .in_re      (re0),
        .gmii_txd   (txd0),
        .gmii_tx_en (ten0),
        .busy       (b0)
    );

    gmii_tx_framer #(.ipg(12), .min_len(60), .pad_en(1'b1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_ready   (in_ready & sel),
        .in_d       (in_d),
        .in_last    (in_last),
        .in_re      (re1),
        .gmii_txd   (txd1),
        .gmii_tx_en (ten1),
        .busy       (b1)
    );

    // Bit-serial reference CRC, returned already complemented
    function automatic logic [31:0] crc_ref(input logic [7:0] q[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic build_exp(input bit pad);
        logic [7:0]  pl[$];
        logic [31:0] fcs;
        pl = {};
        for (int i = 0; i < pkt_len; i++) pl.push_back(pkt_mem[i]);
        if (pad) while (pl.size() < 60) pl.push_back(8'h00);
        fcs = crc_ref(pl);
        exp_q = {};
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (pl[i]) exp_q.push_back(pl[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
    endtask

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic collect(output int lead, output int re_cnt, output bit to);
        bit started;
        started = 1'b0;
        lead    = 0;
        re_cnt  = 0;
        to      = 1'b1;
        got_q   = {};
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (in_re_a) re_cnt++;
            if (tx_en_a) begin
                started = 1'b1;
                got_q.push_back(txd_a);
            end else if (started) begin
                to = 1'b0;
                break;
            end else begin
                lead++;
            end
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy_a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_idle timeout busy=%0b required=0", busy_a);
        end
    endtask

    task automatic start_pkt();
        wait_idle();
        in_ready = 1'b1;
        @(negedge clk);
        in_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_ready = 1'b0;
        sel      = 1'b0;
        pkt_len  = 1;
        repeat (3) @(negedge clk);
        checks++; if (ten0 !== 1'b0) begin failures++; $display("FAIL reset_tx_en got=%0b exp=0", ten0); end
        checks++; if (txd0 !== 8'h00) begin failures++; $display("FAIL reset_txd got=%02h exp=00", txd0); end
        checks++; if (re0 !== 1'b0) begin failures++; $display("FAIL reset_in_re got=%0b exp=0", re0); end
        checks++; if (b0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", b0); end
        checks++; if ({ten1, b1, re1} !== 3'b000) begin failures++; $display("FAIL reset_dut1 got=%03b exp=000", {ten1, b1, re1}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        sel     = 1'b0;
        pkt_len = 3;
        for (int i = 0; i < 3; i++) pkt_mem[i] = 8'($urandom);
        wait_idle();
        in_ready = 1'b1;
        @(negedge clk);
        checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL lat_busy got=%0b exp=1", b0); end
        checks++; if (ten0 !== 1'b0) begin failures++; $display("FAIL lat_tx_en_early got=%0b exp=0", ten0); end
        in_ready = 1'b0;
        @(negedge clk);
        checks++; if ({ten0, txd0} !== {1'b1, 8'h55}) begin failures++; $display("FAIL lat_first_pre got=%0b/%02h exp=1/55", ten0, txd0); end
        wait_idle();
    endtask

    task automatic test_check_value();
        int lead, rc, d;
        bit to;
        logic [31:0] tail;
        sel     = 1'b0;
        pkt_len = 9;
        for (int i = 0; i < 9; i++) pkt_mem[i] = 8'h31 + 8'(i);
        build_exp(1'b0);
        start_pkt();
        collect(lead, rc, to);
        checks++; if (to) begin failures++; $display("FAIL cv_timeout got=1 exp=0"); end
        checks++; if (got_q.size() !== 21) begin failures++; $display("FAIL cv_len got=%0d exp=21", got_q.size()); end
        d = first_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL cv_bytes first_bad_index=%0d exp=-1", d); end
        checks++; if (rc !== 9) begin failures++; $display("FAIL cv_in_re got=%0d exp=9", rc); end
        tail = 32'h0;
        if (got_q.size() >= 4) tail = {got_q[$-3], got_q[$-2], got_q[$-1], got_q[$]};
        checks++; if (tail !== 32'h2639F4CB) begin failures++; $display("FAIL cv_fcs got=%08h exp=2639F4CB", tail); end
    endtask

    task automatic test_padding();
        int lead, rc, d;
        bit to;
        sel        = 1'b1;
        pkt_len    = 1;
        pkt_mem[0] = 8'hAB;
        build_exp(1'b1);
        start_pkt();
        collect(lead, rc, to);
        checks++; if (got_q.size() !== 72) begin failures++; $display("FAIL pad_len got=%0d exp=72", got_q.size()); end
        d = first_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL pad_bytes first_bad_index=%0d exp=-1", d); end
        checks++; if (rc !== 1) begin failures++; $display("FAIL pad_in_re got=%0d exp=1", rc); end
    endtask

    task automatic test_exact_min();
        int lead, rc, d;
        bit to;
        sel     = 1'b1;
        pkt_len = 60;
        for (int i = 0; i < 60; i++) pkt_mem[i] = 8'($urandom);
        build_exp(1'b1);
        start_pkt();
        collect(lead, rc, to);
        checks++; if (got_q.size() !== 72) begin failures++; $display("FAIL min_len got=%0d exp=72", got_q.size()); end
        d = first_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL min_bytes first_bad_index=%0d exp=-1", d); end
        checks++; if (rc !== 60) begin failures++; $display("FAIL min_in_re got=%0d exp=60", rc); end
    endtask

    task automatic test_back_to_back();
        int lead1, rc1, lead2, rc2, d1, d2, n1;
        bit to1, to2;
        sel     = 1'b1;
        pkt_len = 64;
        for (int i = 0; i < 64; i++) pkt_mem[i] = 8'($urandom);
        build_exp(1'b1);
        wait_idle();
        in_ready = 1'b1;
        collect(lead1, rc1, to1);
        d1 = first_diff();
        n1 = got_q.size();
        collect(lead2, rc2, to2);
        in_ready = 1'b0;
        d2 = first_diff();
        checks++; if (n1 !== 76 || d1 != -1) begin failures++; $display("FAIL b2b_frame1 len=%0d bad_index=%0d exp=76/-1", n1, d1); end
        checks++; if (got_q.size() !== 76 || d2 != -1) begin failures++; $display("FAIL b2b_frame2 len=%0d bad_index=%0d exp=76/-1", got_q.size(), d2); end
        checks++; if (lead2 + 1 !== 13) begin failures++; $display("FAIL b2b_gap got=%0d exp=13", lead2 + 1); end
        checks++; if (rc1 + rc2 !== 128) begin failures++; $display("FAIL b2b_in_re got=%0d exp=128", rc1 + rc2); end
    endtask

    task automatic test_mid_reset();
        int lead, rc, d;
        bit to;
        sel     = 1'b1;
        pkt_len = 200;
        for (int i = 0; i < 200; i++) pkt_mem[i] = 8'($urandom);
        build_exp(1'b1);
        start_pkt();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_re_a) break;
        end
        repeat (5) @(negedge clk);
        rst_n    = 1'b0;
        in_ready = 1'b1;
        @(negedge clk);
        checks++; if (ten1 !== 1'b0) begin failures++; $display("FAIL rst_tx_en got=%0b exp=0", ten1); end
        checks++; if (re1 !== 1'b0) begin failures++; $display("FAIL rst_in_re got=%0b exp=0", re1); end
        checks++; if (b1 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", b1); end
        rst_n = 1'b1;
        collect(lead, rc, to);
        in_ready = 1'b0;
        d = first_diff();
        checks++; if (to || d != -1) begin failures++; $display("FAIL rst_new_frame timeout=%0b bad_index=%0d exp=0/-1", to, d); end
        checks++; if (rc !== 200) begin failures++; $display("FAIL rst_in_re_count got=%0d exp=200", rc); end
    endtask

    task automatic test_random();
        int lead, rc, d, exp_len;
        bit to;
        for (int k = 0; k < 8; k++) begin
            sel     = k[0];
            pkt_len = (k < 3) ? int'($urandom_range(1, 70)) : int'($urandom_range(1, 1600));
            for (int i = 0; i < pkt_len; i++) pkt_mem[i] = 8'($urandom);
            build_exp(sel);
            exp_len = 12 + ((sel && pkt_len < 60) ? 60 : pkt_len);
            start_pkt();
            collect(lead, rc, to);
            d = first_diff();
            checks++; if (got_q.size() !== exp_len) begin failures++; $display("FAIL rnd_len[%0d] L=%0d got=%0d exp=%0d", k, pkt_len, got_q.size(), exp_len); end
            checks++; if (d != -1) begin failures++; $display("FAIL rnd_bytes[%0d] L=%0d first_bad_index=%0d exp=-1", k, pkt_len, d); end
            checks++; if (rc !== pkt_len) begin failures++; $display("FAIL rnd_in_re[%0d] got=%0d exp=%0d", k, rc, pkt_len); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_check_value();
        test_padding();
        test_exact_min();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
